// File: rtl/ifetch_queue.sv
// Instruction fetch queue: fetches LC-3b words over mem_read/mem_resp, buffers
// them with their next-PC, and hands them to the IR as a one-cycle load strobe.
module ifetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_address,
  output logic        mem_read,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  input  logic        take,
  output logic        ir_avail,
  output logic        ir_load,
  output logic [15:0] ir_word,
  output logic [15:0] ir_npc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [15:0]     r_fpc;
  logic [15:0]     r_req_addr;
  logic [15:0]     r_word_mem [DEPTH];
  logic [15:0]     r_npc_mem  [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  // A response that races a redirect belongs to the abandoned stream.
  assign w_push = (r_state == REQ) && mem_resp && !redirect;
  assign w_pop  = take && (r_count != '0) && !redirect;

  assign ir_avail    = (r_count != '0);
  assign mem_read    = (r_state != IDLE);
  // DRAIN keeps the old address on the bus while fpc already holds the target.
  assign mem_address = (r_state == IDLE) ? r_fpc : r_req_addr;

  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (!redirect && ((r_count < CW'(DEPTH)) || w_pop)) w_next_state = REQ;
      REQ:     if (mem_resp) w_next_state = IDLE;
               else if (redirect) w_next_state = DRAIN;
      DRAIN:   if (mem_resp) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fpc      <= RESET_PC & 16'hFFFE;
      r_req_addr <= RESET_PC & 16'hFFFE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      ir_load    <= 1'b0;
      ir_word    <= '0;
      ir_npc     <= '0;
    end else begin
      r_state <= w_next_state;
      ir_load <= w_pop;

      if (r_state == IDLE && w_next_state == REQ) r_req_addr <= r_fpc;

      if (redirect)    r_fpc <= redirect_pc & 16'hFFFE;
      else if (w_push) r_fpc <= r_fpc + 16'd2;

      if (w_pop) begin
        ir_word <= r_word_mem[r_rptr];
        ir_npc  <= r_npc_mem[r_rptr];
      end

      if (redirect) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // NOTE: storage is not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_word_mem[r_wptr] <= mem_rdata;
      r_npc_mem[r_wptr]  <= r_fpc + 16'd2;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed fetch/redirect/reset scenarios,
// with IR-load outputs checked by a scoreboard monitor.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] mem_address, mem_rdata, ir_word, ir_npc, redirect_pc;
  logic        mem_read, mem_resp, take, ir_avail, ir_load, redirect;

  logic [15:0] b_mem_address, b_mem_rdata, b_ir_word, b_ir_npc, b_redirect_pc;
  logic        b_mem_read, b_mem_resp, b_take, b_ir_avail, b_ir_load, b_redirect;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  bit resp_en  = 1'b1;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] npc;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];
  exp_t a_e, b_e;

  ifetch_queue u_dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .take(take), .ir_avail(ir_avail), .ir_load(ir_load),
    .ir_word(ir_word), .ir_npc(ir_npc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  ifetch_queue #(.DEPTH(2), .RESET_PC(16'hFFFE)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .mem_address(b_mem_address), .mem_read(b_mem_read),
    .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp),
    .take(b_take), .ir_avail(b_ir_avail), .ir_load(b_ir_load),
    .ir_word(b_ir_word), .ir_npc(b_ir_npc),
    .redirect(b_redirect), .redirect_pc(b_redirect_pc)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    return addr ^ 16'h1234;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (mem_resp !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (mem_resp !== 1'b1) check("resp_timeout", 16'(mem_resp), 16'h1);
  endtask

  // Memory model for the first instance: responds `lat` cycles after mem_read.
  initial begin
    int cnt;
    cnt = 0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        mem_resp = 1'b0;
        if (mem_read) begin
          cnt++;
          if (cnt >= lat) begin
            mem_resp  = 1'b1;
            mem_rdata = mem_word(mem_address);
            cnt = 0;
          end
        end else cnt = 0;
      end else cnt = 0;
    end
  end

  // Memory model for the wrap instance: always one-cycle response.
  initial begin
    b_mem_resp  = 1'b0;
    b_mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      b_mem_resp = 1'b0;
      if (b_mem_read) begin
        b_mem_resp  = 1'b1;
        b_mem_rdata = mem_word(b_mem_address);
      end
    end
  end

  // Scoreboard monitor: every IR load must match the oldest expected entry.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (ir_load === 1'b1) begin
        if (a_q.size() == 0) check("a_unexpected_ir_load", 16'(ir_load), 16'h0);
        else begin
          a_e = a_q.pop_front();
          check("a_ir_word", ir_word, a_e.word);
          check("a_ir_npc", ir_npc, a_e.npc);
        end
      end
      if (b_ir_load === 1'b1) begin
        if (b_q.size() == 0) check("b_unexpected_ir_load", 16'(b_ir_load), 16'h0);
        else begin
          b_e = b_q.pop_front();
          check("b_ir_word", b_ir_word, b_e.word);
          check("b_ir_npc", b_ir_npc, b_e.npc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; take = 1'b0; redirect = 1'b0; redirect_pc = '0;
    b_take = 1'b0; b_redirect = 1'b0; b_redirect_pc = '0;
    repeat (3) tick();

    check("rst_mem_read", 16'(mem_read), 16'h0);
    check("rst_mem_address", mem_address, 16'h0000);
    check("rst_ir_load", 16'(ir_load), 16'h0);
    check("rst_ir_word", ir_word, 16'h0000);
    check("rst_ir_npc", ir_npc, 16'h0000);
    check("rst_ir_avail", 16'(ir_avail), 16'h0);
    check("b_rst_mem_address", b_mem_address, 16'hFFFE);

    // Fill: fetches at 0000 and 0002, then stall with the queue full.
    reset = 1'b0;
    tick();
    check("first_mem_read", 16'(mem_read), 16'h1);
    check("first_addr", mem_address, 16'h0000);
    check("b_first_mem_read", 16'(b_mem_read), 16'h1);
    check("b_first_addr", b_mem_address, 16'hFFFE);
    tick();
    check("avail_after_resp", 16'(ir_avail), 16'h1);
    check("read_gap", 16'(mem_read), 16'h0);
    tick();
    check("second_mem_read", 16'(mem_read), 16'h1);
    check("second_addr", mem_address, 16'h0002);
    check("b_second_addr", b_mem_address, 16'h0000);
    tick();
    repeat (4) begin
      tick();
      check("stall_no_req", 16'(mem_read), 16'h0);
    end
    check("stall_fpc", mem_address, 16'h0004);

    // Wrap instance: first entry fetched at FFFE carries npc 0000.
    b_q.push_back({16'hEDCA, 16'h0000});
    b_take = 1'b1;
    tick();
    b_take = 1'b0;

    // Pop re-enables fetch at 0004; memory now answers after 3 cycles.
    lat = 3;
    a_q.push_back({16'h1234, 16'h0002});
    take = 1'b1;
    tick();
    take = 1'b0;
    check("refetch_read", 16'(mem_read), 16'h1);
    check("refetch_addr", mem_address, 16'h0004);

    // Redirect while the 0004 read is outstanding.
    redirect = 1'b1; redirect_pc = 16'h3001;
    tick();
    redirect = 1'b0;
    check("drain_read", 16'(mem_read), 16'h1);
    check("drain_addr", mem_address, 16'h0004);
    check("drain_flushed", 16'(ir_avail), 16'h0);
    tick();
    check("drain_addr_hold", mem_address, 16'h0004);
    tick();
    check("drain_done_read", 16'(mem_read), 16'h0);
    check("drain_discard", 16'(ir_avail), 16'h0);
    tick();
    check("redir_read", 16'(mem_read), 16'h1);
    check("redir_addr", mem_address, 16'h3000);

    wait_resp();
    tick();
    check("avail_3000", 16'(ir_avail), 16'h1);

    // Redirect, mem_resp and take all in the same cycle.
    wait_resp();
    check("addr_3002", mem_address, 16'h3002);
    redirect = 1'b1; redirect_pc = 16'h0100; take = 1'b1;
    tick();
    redirect = 1'b0; take = 1'b0;
    check("race_no_push", 16'(ir_avail), 16'h0);
    check("race_idle", 16'(mem_read), 16'h0);
    check("race_no_load", 16'(ir_load), 16'h0);
    tick();
    check("race_read", 16'(mem_read), 16'h1);
    check("race_addr", mem_address, 16'h0100);

    wait_resp();
    tick();
    a_q.push_back({16'h1334, 16'h0102});
    take = 1'b1;
    tick();
    take = 1'b0;
    check("pre_reset_read", 16'(mem_read), 16'h1);

    // Reset with a read outstanding; a late response must be ignored.
    resp_en = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_rst_mem_read", 16'(mem_read), 16'h0);
    check("mid_rst_addr", mem_address, 16'h0000);
    check("mid_rst_ir_load", 16'(ir_load), 16'h0);
    check("mid_rst_ir_word", ir_word, 16'h0000);
    check("mid_rst_ir_npc", ir_npc, 16'h0000);
    check("mid_rst_avail", 16'(ir_avail), 16'h0);
    reset = 1'b0;
    mem_resp = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_resp = 1'b0;
    check("late_resp_ignored", 16'(ir_avail), 16'h0);
    check("post_rst_read", 16'(mem_read), 16'h1);
    check("post_rst_addr", mem_address, 16'h0000);
    tick();
    check("late_resp_still_empty", 16'(ir_avail), 16'h0);

    check("a_scoreboard_empty", 16'(a_q.size()), 16'h0);
    check("b_scoreboard_empty", 16'(b_q.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
